// File: rtl/RS5_pkg.sv
// rtl/RS5_pkg.sv - shared types for the RAM port arbiter
package RS5_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_master_e;

    // The master that wins a tie after m was granted last.
    function automatic arb_master_e arb_other(input arb_master_e m);
        return (m == ARB_CPU) ? ARB_DMA : ARB_CPU;
    endfunction

    // Locked-ownership state belonging to master m.
    function automatic arb_state_e arb_own_state(input arb_master_e m);
        return (m == ARB_CPU) ? OWN_CPU : OWN_DMA;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-master round-robin arbiter with lock for a sync RAM port
module ram_port_arbiter
    import RS5_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int AW       = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req_i,
    input  logic          cpu_lock_i,
    input  logic [3:0]    cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [31:0]   cpu_data_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,

    input  logic          dma_req_i,
    input  logic          dma_lock_i,
    input  logic [3:0]    dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [31:0]   dma_data_i,
    output logic          dma_gnt_o,
    output logic          dma_rvalid_o,

    output logic [31:0]   m_rdata_o,

    output logic          ram_en_o,
    output logic [3:0]    ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_data_o,
    input  logic [31:0]   ram_data_i
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    arb_state_e  state, state_nxt;
    arb_master_e last_gnt, last_gnt_nxt;
    logic [CW-1:0] idle_cnt, idle_cnt_nxt;

    logic        grant;
    arb_master_e winner;
    arb_master_e owner;
    logic        owner_req;
    logic        owner_lock;
    logic        win_lock;

    logic        rsp_valid;
    arb_master_e rsp_tag;

    // Arbitration decision and next-state for the ownership FSM.
    always_comb begin
        grant        = 1'b0;
        winner       = ARB_CPU;
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        idle_cnt_nxt = idle_cnt;
        owner        = (state == OWN_DMA) ? ARB_DMA : ARB_CPU;
        owner_req    = (owner == ARB_CPU) ? cpu_req_i  : dma_req_i;
        owner_lock   = (owner == ARB_CPU) ? cpu_lock_i : dma_lock_i;
        win_lock     = 1'b0;

        case (state)
            IDLE: begin
                idle_cnt_nxt = '0;
                if (cpu_req_i && dma_req_i) begin
                    grant  = 1'b1;
                    winner = arb_other(last_gnt);
                end else if (cpu_req_i) begin
                    grant  = 1'b1;
                    winner = ARB_CPU;
                end else if (dma_req_i) begin
                    grant  = 1'b1;
                    winner = ARB_DMA;
                end
                win_lock = (winner == ARB_CPU) ? cpu_lock_i : dma_lock_i;
                if (grant) begin
                    last_gnt_nxt = winner;
                    if (win_lock) begin
                        state_nxt = arb_own_state(winner);
                    end
                end
            end
            OWN_CPU, OWN_DMA: begin
                if (owner_req) begin
                    grant        = 1'b1;
                    winner       = owner;
                    last_gnt_nxt = owner;
                    idle_cnt_nxt = '0;
                    if (!owner_lock) begin
                        state_nxt = IDLE;
                    end
                end else if (idle_cnt == CNT_LAST) begin
                    // Owner went quiet too long: release, and make the other
                    // master win the next tie.
                    state_nxt    = IDLE;
                    idle_cnt_nxt = '0;
                    last_gnt_nxt = owner;
                end else begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                idle_cnt_nxt = '0;
            end
        endcase

        if (reset) begin
            grant = 1'b0;
        end
    end

    // Steer the winning master onto the RAM port; park everything when idle.
    always_comb begin
        cpu_gnt_o  = grant && (winner == ARB_CPU);
        dma_gnt_o  = grant && (winner == ARB_DMA);
        ram_en_o   = grant;
        ram_we_o   = 4'b0000;
        ram_addr_o = '0;
        ram_data_o = '0;
        if (grant) begin
            if (winner == ARB_CPU) begin
                ram_we_o   = cpu_we_i;
                ram_addr_o = cpu_addr_i;
                ram_data_o = cpu_data_i;
            end else begin
                ram_we_o   = dma_we_i;
                ram_addr_o = dma_addr_i;
                ram_data_o = dma_data_i;
            end
        end
    end

    // Ownership FSM, round-robin history and idle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= ARB_DMA;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Capture who issued a read so its data is routed back one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_tag   <= ARB_CPU;
        end else begin
            rsp_valid <= grant && (ram_we_o == 4'b0000);
            if (grant) begin
                rsp_tag <= winner;
            end
        end
    end

    assign cpu_rvalid_o = rsp_valid && (rsp_tag == ARB_CPU);
    assign dma_rvalid_o = rsp_valid && (rsp_tag == ARB_DMA);
    assign m_rdata_o    = ram_data_i;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16, meaning max idle cycles a locked owner may hold the port without requesting.
REQ-002 SHALL have parameter AW, default 16, meaning RAM address width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cpu_req_i / dma_req_i  input  1  per-master access request.
REQ-006 SHALL have ports cpu_lock_i / dma_lock_i  input  1  keep ownership after this access (AMO read-modify-write, DMA burst).
REQ-007 SHALL have ports cpu_we_i / dma_we_i  input  4  byte write enables; 0 means read.
REQ-008 SHALL have ports cpu_addr_i / dma_addr_i  input  AW  byte address.
REQ-009 SHALL have ports cpu_data_i / dma_data_i  input  32  write data.
REQ-010 SHALL have ports cpu_gnt_o / dma_gnt_o  output  1  access accepted this cycle.
REQ-011 SHALL have ports cpu_rvalid_o / dma_rvalid_o  output  1  read data valid.
REQ-012 SHALL have port m_rdata_o  output  32  read data shared by both masters; qualified by the rvalid outputs.
REQ-013 SHALL have ports ram_en_o 1, ram_we_o 4, ram_addr_o AW, ram_data_o 32 (outputs), and ram_data_i 32 (input), the synchronous RAM port B with 1-cycle read latency.

Function
REQ-014 SHALL implement FSM states IDLE, OWN_CPU, OWN_DMA.
REQ-015 SHALL compute grant combinationally in the same cycle as the request; a granted access SHALL drive ram_en_o=1 and the winner's we, addr and data in that cycle.
REQ-016 SHALL, in IDLE with one requester, grant that requester.
REQ-017 SHALL, in IDLE with both requesting, grant the master not granted last, using a last_gnt register updated on every grant.
REQ-018 SHALL, in OWN_x, grant only master x; the other master's gnt SHALL stay 0.
REQ-019 SHALL move to OWN_x when master x is granted with lock=1.
REQ-020 SHALL return to IDLE when the owner is granted with lock=0.
REQ-021 SHALL keep an idle counter in OWN_x that resets to 0 on each owner request and increments on each cycle without one.
REQ-022 SHALL force the FSM to IDLE when the idle counter reaches LOCK_MAX; on that forced exit, ownership passes to the other master first if both request.
REQ-023 SHALL drive ram_en_o=0, all ram_we_o=0 and both gnt=0 when no access is granted.
REQ-024 SHALL, exactly one cycle after a granted read (we=0), pulse the granting master's rvalid for one cycle with m_rdata_o = ram_data_i.
REQ-025 SHALL route that response using a registered tag captured at grant time, so a new grant in the response cycle does not misroute it.
REQ-026 SHALL NOT produce rvalid for granted writes.
REQ-027 SHALL allow back-to-back reads every cycle from either master, giving throughput of 1 access/cycle.

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, last_gnt=DMA (CPU wins first tie), idle counter=0, response tag cleared, and both rvalid=0.
REQ-029 SHALL, while reset=1, force gnt=0 and ram_en_o=0 regardless of requests.
REQ-030 SHALL drop any read in flight when reset asserts, with no rvalid after reset deasserts.

Structure
REQ-031 SHALL declare the FSM enum (arb_state_e) and master-ID enum (arb_master_e: ARB_CPU, ARB_DMA) in RS5_pkg.
REQ-032 SHALL be a single module with no sub-module; round-robin and lock logic stay inline.

Verification
REQ-033 SHALL cover tie arbitration: both read from reset (cpu addr 0x0010, dma addr 0x0020) for 4 cycles -> grants CPU, DMA, CPU, DMA; each rvalid one cycle later with the matching RAM word.
REQ-034 SHALL cover a locked AMO: CPU read 0x0100 with lock=1, then write 0x0100 with lock=0 while DMA requests continuously -> DMA gnt=0 for both cycles, then DMA granted next cycle.
REQ-035 SHALL cover lock timeout: DMA granted with lock=1, then DMA req=0 for 16 cycles while CPU requests -> CPU gnt rises on cycle 17, state IDLE.
REQ-036 SHALL cover a write: CPU write we=4'b0011, data 0xDEADBEEF to 0x0040 -> ram_we_o=4'b0011 the same cycle, no rvalid; a later read of 0x0040 returns 0x????BEEF.
REQ-037 SHALL cover reset mid-read: reset asserted the cycle after a granted DMA read -> dma_rvalid_o stays 0 and state is IDLE.
REQ-038 SHALL cover response routing: CPU read, then DMA read the next cycle -> cpu_rvalid_o then dma_rvalid_o on consecutive cycles, never both at once.
